// File: rtl/feeder_pkg.sv
// ---------------------------------------------------------------------------
// feeder_pkg
//   Shared types and constants for the pixel line feeder.
//   - FDR_PIX_W / FDR_PIX_N / FDR_BLK_H : default geometry
//   - LW                                : line width in bits (PIX_W*PIX_N)
//   - feeder_state_e                    : IDLE / PRIME / RUN / DRAIN
//   - rep_sel_e                         : line-window load mode
//   - row_cnt_w()                       : row counter width for a block height
// ---------------------------------------------------------------------------
package feeder_pkg;

    localparam int FDR_PIX_W = 8;
    localparam int FDR_PIX_N = 8;
    localparam int FDR_BLK_H = 8;
    localparam int LW        = FDR_PIX_W * FDR_PIX_N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } feeder_state_e;

    // REP_NONE: plain shift (upper<-middle, middle<-lower, lower<-line_in)
    // REP_TOP : top-edge prime, middle and lower both take line_in
    // REP_BOT : bottom-edge shift, lower keeps its value so it equals the new middle
    typedef enum logic [1:0] {
        REP_NONE = 2'd0,
        REP_TOP  = 2'd1,
        REP_BOT  = 2'd2
    } rep_sel_e;

    function automatic int row_cnt_w(input int blk_h);
        return (blk_h > 1) ? $clog2(blk_h) : 1;
    endfunction

    localparam int FDR_ROW_W = row_cnt_w(FDR_BLK_H);

endpackage

// File: rtl/line_window.sv
// ---------------------------------------------------------------------------
// line_window
//   Three-line vertical window (upper/middle/lower) built as a shift register
//   of current-picture lines.
//   Ports:
//     clk, rst        clock, synchronous active-high reset (clears all lines)
//     load_en         advance the window this cycle
//     rep_sel         load mode (plain shift, top replicate, bottom replicate)
//     line_in         incoming line
//     upper/middle/lower  registered window lines
// ---------------------------------------------------------------------------
module line_window
    import feeder_pkg::*;
#(
    parameter int WIDTH = LW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  rep_sel_e         rep_sel,
    input  logic [WIDTH-1:0] line_in,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] middle,
    output logic [WIDTH-1:0] lower
);

    logic [WIDTH-1:0] upper_q,  upper_d;
    logic [WIDTH-1:0] middle_q, middle_d;
    logic [WIDTH-1:0] lower_q,  lower_d;

    always_comb begin
        upper_d  = upper_q;
        middle_d = middle_q;
        lower_d  = lower_q;
        if (load_en) begin
            case (rep_sel)
                REP_NONE: begin
                    upper_d  = middle_q;
                    middle_d = lower_q;
                    lower_d  = line_in;
                end
                // Upper is left alone: the first row shift copies middle
                // (the replicated line) into it.
                REP_TOP: begin
                    middle_d = line_in;
                    lower_d  = line_in;
                end
                // No new line: lower holds, so after the shift it duplicates middle.
                REP_BOT: begin
                    upper_d  = middle_q;
                    middle_d = lower_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upper_q  <= '0;
            middle_q <= '0;
            lower_q  <= '0;
        end else begin
            upper_q  <= upper_d;
            middle_q <= middle_d;
            lower_q  <= lower_d;
        end
    end

    assign upper  = upper_q;
    assign middle = middle_q;
    assign lower  = lower_q;

endmodule

// File: rtl/pix_line_feeder.sv
// ---------------------------------------------------------------------------
// pix_line_feeder
//   Feeds aligned current-picture line windows plus the matching original
//   line into the abs-diff/SAD datapath, one row per cycle for a BLK_H-row
//   block.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     start                      one-cycle block start (IDLE only)
//     pad_top, pad_bot           edge-replicate flags, sampled with start
//                                (present only when FEEDER_EDGE_PAD_EN is defined)
//     cur_valid/cur_ready/cur_line  current-line stream
//     org_valid/org_ready/org_line  original-line stream
//     out_valid/out_ready        output handshake
//     cur_upper_pix/cur_middle_pix/cur_lower_pix/org_pix  window + org line
//     out_last                   marks the final row of the block
//     busy                       high whenever the FSM is not IDLE
//   Build option: FEEDER_EDGE_PAD_EN enables top/bottom edge replication.
// ---------------------------------------------------------------------------
module pix_line_feeder
    import feeder_pkg::*;
#(
    parameter int PIX_W = FDR_PIX_W,
    parameter int PIX_N = FDR_PIX_N,
    parameter int BLK_H = FDR_BLK_H
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
`ifdef FEEDER_EDGE_PAD_EN
    input  logic                   pad_top,
    input  logic                   pad_bot,
`endif
    input  logic                   cur_valid,
    output logic                   cur_ready,
    input  logic [PIX_W*PIX_N-1:0] cur_line,
    input  logic                   org_valid,
    output logic                   org_ready,
    input  logic [PIX_W*PIX_N-1:0] org_line,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIX_W*PIX_N-1:0] cur_upper_pix,
    output logic [PIX_W*PIX_N-1:0] cur_middle_pix,
    output logic [PIX_W*PIX_N-1:0] cur_lower_pix,
    output logic [PIX_W*PIX_N-1:0] org_pix,
    output logic                   out_last,
    output logic                   busy
);

    localparam int LINE_W = PIX_W * PIX_N;
    localparam int RW     = row_cnt_w(BLK_H);

    feeder_state_e     state_q,     state_d;
    logic [RW-1:0]     row_cnt_q,   row_cnt_d;
    logic              prime_cnt_q, prime_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic              busy_q,      busy_d;
    logic [LINE_W-1:0] org_q,       org_d;
    logic              pad_top_q,   pad_top_d;
    logic              pad_bot_q,   pad_bot_d;

    logic     slot_free;
    logic     last_row;
    logic     need_cur;
    logic     xfer;
    logic     cur_rdy;
    logic     org_rdy;
    logic     win_load;
    rep_sel_e win_rep;

    assign slot_free = !out_valid_q || out_ready;
    assign last_row  = (row_cnt_q == RW'(BLK_H - 1));
    // With bottom padding the final row is built from lines already held.
    assign need_cur  = !(pad_bot_q && last_row);

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        prime_cnt_d = prime_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        org_d       = org_q;
        cur_rdy     = 1'b0;
        org_rdy     = 1'b0;
        xfer        = 1'b0;
        win_load    = 1'b0;
        win_rep     = REP_NONE;
`ifdef FEEDER_EDGE_PAD_EN
        pad_top_d   = (state_q == IDLE && start) ? pad_top : pad_top_q;
        pad_bot_d   = (state_q == IDLE && start) ? pad_bot : pad_bot_q;
`else
        pad_top_d   = 1'b0;
        pad_bot_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PRIME;
                    row_cnt_d   = '0;
                    prime_cnt_d = 1'b0;
                end
            end

            // Load lines -1 and 0 so the first RUN beat completes the window.
            PRIME: begin
                cur_rdy = 1'b1;
                if (cur_valid) begin
                    win_load = 1'b1;
                    if (pad_top_q) begin
                        win_rep = REP_TOP;
                        state_d = RUN;
                    end else begin
                        prime_cnt_d = 1'b1;
                        if (prime_cnt_q) state_d = RUN;
                    end
                end
            end

            // Both streams move together so window and org line stay aligned.
            RUN: begin
                xfer    = slot_free && org_valid && (cur_valid || !need_cur);
                cur_rdy = xfer && need_cur;
                org_rdy = xfer;
                if (xfer) begin
                    win_load    = 1'b1;
                    win_rep     = need_cur ? REP_NONE : REP_BOT;
                    org_d       = org_line;
                    out_valid_d = 1'b1;
                    out_last_d  = last_row;
                    row_cnt_d   = row_cnt_q + RW'(1);
                    if (last_row) state_d = DRAIN;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end

            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            prime_cnt_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            org_q       <= '0;
            pad_top_q   <= 1'b0;
            pad_bot_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            prime_cnt_q <= prime_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            org_q       <= org_d;
            pad_top_q   <= pad_top_d;
            pad_bot_q   <= pad_bot_d;
        end
    end

    line_window #(
        .WIDTH (LINE_W)
    ) u_window (
        .clk     (clk),
        .rst     (rst),
        .load_en (win_load),
        .rep_sel (win_rep),
        .line_in (cur_line),
        .upper   (cur_upper_pix),
        .middle  (cur_middle_pix),
        .lower   (cur_lower_pix)
    );

    assign cur_ready = cur_rdy;
    assign org_ready = org_rdy;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign org_pix   = org_q;

endmodule

// File: tb/tb_pix_line_feeder.sv
`timescale 1ns/1ps
module tb_pix_line_feeder;

    localparam int LW = 64;
    localparam int BH = 8;
    typedef logic [4*LW:0]   row_t;
    typedef logic [4*LW+1:0] cmp_t;

    logic          clk = 1'b0;
    logic          rst, start;
`ifdef FEEDER_EDGE_PAD_EN
    logic          pad_top, pad_bot;
`endif
    logic          cur_valid, cur_ready, org_valid, org_ready;
    logic [LW-1:0] cur_line, org_line;
    logic          out_valid, out_ready, out_last, busy;
    logic [LW-1:0] up, mid, lo, org_pix;

    pix_line_feeder #(.PIX_W(8), .PIX_N(8), .BLK_H(BH)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef FEEDER_EDGE_PAD_EN
        .pad_top        (pad_top),
        .pad_bot        (pad_bot),
`endif
        .cur_valid      (cur_valid),
        .cur_ready      (cur_ready),
        .cur_line       (cur_line),
        .org_valid      (org_valid),
        .org_ready      (org_ready),
        .org_line       (org_line),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .cur_upper_pix  (up),
        .cur_middle_pix (mid),
        .cur_lower_pix  (lo),
        .org_pix        (org_pix),
        .out_last       (out_last),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    int   total = 0;
    int   bad   = 0;
    row_t sb[$];
    row_t mon_e;

    int cur_base = 0, cur_n = 0, cur_idx = 0, cur_cnt = 0;
    int org_base = 0, org_n = 0, org_idx = 0, org_cnt = 0;
    bit org_en = 1'b1;
    int blk_cb = 0, blk_ob = 0;
    bit blk_pt = 1'b0, blk_pb = 1'b0;

    function automatic logic [LW-1:0] rep(input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {8{bb}};
    endfunction

    // Row k of the current block: arrival-indexed current lines around k.
    function automatic row_t exp_row(input int k);
        int m, u, l;
        m = blk_pt ? k : k + 1;
        u = (blk_pt && k == 0) ? m : m - 1;
        l = (blk_pb && k == BH - 1) ? m : m + 1;
        return {(k == BH - 1), rep(blk_cb + u), rep(blk_cb + m), rep(blk_cb + l), rep(blk_ob + k)};
    endfunction

    task automatic chk(input string nm, input cmp_t act, input cmp_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        cur_valid = (cur_idx < cur_n);
        cur_line  = cur_valid ? rep(cur_base + cur_idx) : '0;
        org_valid = org_en && (org_idx < org_n);
        org_line  = org_valid ? rep(org_base + org_idx) : '0;
    endtask

    // One clock: handshakes sampled at the falling edge, sources advanced after the rising edge.
    task automatic step();
        bit cf, of;
        drive();
        @(negedge clk);
        cf = cur_valid && cur_ready;
        of = org_valid && org_ready;
        @(posedge clk);
        #1;
        if (cf) begin cur_idx++; cur_cnt++; end
        if (of) begin org_idx++; org_cnt++; end
        drive();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {out_valid, out_last, busy, cur_ready, org_ready}, '0);
        chk({tag, "_pix"}, {up, mid, lo, org_pix}, '0);
    endtask

    task automatic load_block(input int cb, input int cn, input int ob, input int on,
                              input bit pt, input bit pb);
        cur_base = cb; cur_n = cn; cur_idx = 0; cur_cnt = 0;
        org_base = ob; org_n = on; org_idx = 0; org_cnt = 0;
        blk_cb = cb; blk_ob = ob; blk_pt = pt; blk_pb = pb;
        for (int k = 0; k < BH; k++) sb.push_back(exp_row(k));
        drive();
    endtask

    // Runs one block; offsets are cycles relative to the start cycle.
    task automatic run_block(input int stall_off, input int stall_len, input int stall_row,
                             input int gap_off, input int gap_len,
                             input int s1, input int s2,
                             output int fv, output int lv);
        int t0, rel;
        bit done;
        fv = -1; lv = -1; done = 1'b0;
        t0 = ecnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            rel       = ecnt - t0;
            out_ready = !(rel >= stall_off && rel < stall_off + stall_len);
            org_en    = !(rel >= gap_off && rel < gap_off + gap_len);
            start     = (rel == s1) || (rel == s2);
            drive();
            #2;
            if (out_valid && fv < 0) fv = rel;
            if (out_valid && out_last && lv < 0) lv = rel;
            if (rel >= stall_off && rel < stall_off + stall_len) begin
                chk("stall_row", {out_last, up, mid, lo, org_pix}, exp_row(stall_row));
                chk("stall_vld", out_valid, 1);
                chk("stall_rdy", {cur_ready, org_ready}, 0);
            end
            if (rel >= gap_off && rel < gap_off + gap_len)
                chk("skew_cur_ready", {cur_valid, cur_ready}, 2'b10);
            step();
            if (!busy) done = 1'b1;
        end
        start = 1'b0; out_ready = 1'b1; org_en = 1'b1;
        if (!done) begin
            total++; bad++;
            $display("FAIL block_timeout: busy still %0d after 100 cycles", busy);
        end
    endtask

    task automatic end_checks(input string tag, input int ncur);
        chk({tag, "_rows_left"}, sb.size(), 0);
        sb.delete();
        chk({tag, "_cur_beats"}, cur_cnt, ncur);
        chk({tag, "_org_beats"}, org_cnt, BH);
        repeat (4) step();
        #1;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_cur_beats"}, cur_cnt, ncur);
    endtask

    // Scoreboard monitor: every accepted output row is checked against the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_row: got %0h expected none", {out_last, up, mid, lo, org_pix});
            end else begin
                mon_e = sb.pop_front();
                if ({out_last, up, mid, lo, org_pix} !== mon_e) begin
                    bad++;
                    $display("FAIL row: got %0h expected %0h", {out_last, up, mid, lo, org_pix}, mon_e);
                end
            end
        end
    end

    initial begin
        int fv, lv;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
`ifdef FEEDER_EDGE_PAD_EN
        pad_top = 1'b0; pad_bot = 1'b0;
`endif
        drive();
        repeat (3) step();
        #1;
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Nominal block: latency and row contents
        load_block(8'h00, 12, 8'hA0, 10, 1'b0, 1'b0);
        run_block(-100, 0, 0, -100, 0, -1, -1, fv, lv);
        chk("first_valid_lat", fv, 4);
        chk("last_row_lat", lv, 11);
        end_checks("nominal", 10);

        // Backpressure on row 2 for 3 cycles
        load_block(8'h10, 12, 8'hB0, 10, 1'b0, 1'b0);
        run_block(6, 3, 2, -100, 0, -1, -1, fv, lv);
        end_checks("bp", 10);

        // org gap in RUN, start in RUN and in a held DRAIN
        load_block(8'h20, 12, 8'h60, 10, 1'b0, 1'b0);
        run_block(13, 2, 7, 5, 2, 7, 14, fv, lv);
        end_checks("skew", 10);

        // Reset while row 3 is presented
        load_block(8'h40, 12, 8'h70, 10, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        #1;
        chk("rst_pre_row3", {out_valid, mid}, {1'b1, rep(8'h44)});
        rst = 1'b1; out_ready = 1'b0;
        step();
        #1;
        chk_reset("midrst");
        rst = 1'b0; out_ready = 1'b1;
        sb.delete();
        step();

        // Fresh block after reset
        load_block(8'h50, 12, 8'hD0, 10, 1'b0, 1'b0);
        run_block(-100, 0, 0, -100, 0, -1, -1, fv, lv);
        chk("fresh_first_valid_lat", fv, 4);
        end_checks("fresh", 10);

`ifdef FEEDER_EDGE_PAD_EN
        pad_top = 1'b1; pad_bot = 1'b1;
        load_block(8'h80, 10, 8'hE0, 10, 1'b1, 1'b1);
        run_block(-100, 0, 0, -100, 0, -1, -1, fv, lv);
        pad_top = 1'b0; pad_bot = 1'b0;
        end_checks("pad", 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pix_line_feeder.md
# pix_line_feeder

Streams current-picture and original-picture pixel lines into the absolute-difference line datapath. It accepts 64-bit lines from two valid/ready streams and keeps a three-line sliding window (upper/middle/lower) of current lines. For each row of a BLK_H-line block it presents one aligned window plus the matching original line. It sits between the line fetch buffers and the abs-diff/SAD pipeline of the fractional motion-estimation path.

## Interface
- PIX_W, 8: bits per pixel
- PIX_N, 8: pixels per line; line width LW = PIX_W*PIX_N (64)
- BLK_H, 8: output rows per block (≥2)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle block start; honoured only in IDLE
- pad_top / pad_bot  in  1 / 1  edge-replicate flags, sampled with start (only with FEEDER_EDGE_PAD_EN)
- cur_valid / cur_ready / cur_line  in / out / in  1 / 1 / LW  current-line stream; pixel 0 in bits [PIX_W-1:0]
- org_valid / org_ready / org_line  in / out / in  1 / 1 / LW  original-line stream, same packing
- out_valid / out_ready  out / in  1 / 1  output handshake
- cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix  out  LW each  window and org line
- out_last  out  1  marks row BLK_H-1
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, PRIME, RUN, DRAIN.
- IDLE: ready outputs 0. start → PRIME; clear row_cnt and prime_cnt.
- PRIME: cur_ready=1, org_ready=0. Accept current lines −1 then 0 into upper/middle shift positions. After 2 beats → RUN.
- RUN, emit row k: slot_free = !out_valid || out_ready.
  - cur_ready = org_ready = slot_free && cur_valid && org_valid. Both streams transfer jointly, never singly.
  - On transfer: upper←middle, middle←lower_stage, lower←cur_line (line k+1); org_pix←org_line (line k); out_valid←1; out_last←(k==BLK_H−1); row_cnt++.
  - After row BLK_H−1 is accepted → DRAIN.
- DRAIN: wait until out_valid && out_ready, then → IDLE. busy drops on the IDLE cycle.
- Output registers hold stable while out_valid && !out_ready.
- Total consumption per block: BLK_H+2 current lines, BLK_H original lines.
- start outside IDLE is ignored. Extra valid beats after a block completes stay unconsumed until the next start.
- rst at any point → IDLE next edge; all counters cleared; mid-block data is discarded.

## Timing
- Reset values: out_valid=0, out_last=0, busy=0, cur_ready=0, org_ready=0, all pixel outputs 0.
- start at cycle t → PRIME at t+1. With continuous valid and out_ready=1, first out_valid at t+4 and the last row at t+3+BLK_H.
- Back-to-back rows at 1 per cycle with no bubbles.
- Registered-output latency: 1 cycle from the accepting beat to out_valid.
- Ready may depend on valid. Valid never depends on ready.

## Configuration
- FEEDER_EDGE_PAD_EN defined:
  - pad_top=1: PRIME consumes only line 0, and upper is loaded with a copy of line 0.
  - pad_bot=1: the final RUN row consumes no current line (cur_ready=0; transfer needs only org_valid), and lower is loaded with a copy of middle.
  - Consumption becomes BLK_H+2−pad_top−pad_bot current lines.
- Undefined: pad ports are absent and the block always consumes BLK_H+2 current lines.

## Structure
- Package feeder_pkg holds LW, the state enum (IDLE/PRIME/RUN/DRAIN) and the row counter width $clog2(BLK_H).
- One sub-module, line_window: a three-register upper/middle/lower shift with a load-enable and a replicate-select. The top level holds the FSM, handshakes and org register.

## Test plan
- Reset mid-RUN (row 3): next cycle out_valid=0, busy=0, pixels 0. A new start then produces rows from fresh lines only.
- Nominal 8×8 block:
  - Stimulus: cur lines 0x00..00 … 0x09..09; org lines 0xA0.. … 0xA7..; start at t.
  - Expected row k: upper=k, middle=k+1, lower=k+2 (replicated byte); org=0xA0+k.
  - out_last only on row 7; first out_valid at t+4.
- Backpressure: hold out_ready=0 for 3 cycles at row 2. Outputs stay frozen, both readys stay 0, no line is lost; rows 3..7 then follow in order.
- Stream skew: org_valid low for 2 cycles in RUN while cur_valid is high. No cur beat is consumed during the gap and the window is unchanged.
- start asserted in RUN and DRAIN → ignored. Exactly 10 cur and 8 org beats consumed per block.
- With FEEDER_EDGE_PAD_EN, pad_top=pad_bot=1: 8 cur beats consumed. Row 0 upper equals middle, row 7 lower equals middle.
